// File: rtl/arith_result_stage.sv
// arith_result_stage: registered result stage after the 32-bit add/subtract unit.
// Captures z/cout through a valid/ready handshake and derives {N, Z, C, V}.
// A 2-entry skid buffer (main + skid) sustains one transfer per cycle
// under backpressure. A saturating counter tracks accepted overflow results.
module arith_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z,
    input  logic             cout,
    input  logic             ctrl,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic [3:0]       out_flags,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_z;
    logic [3:0]       main_flags;
    logic [WIDTH-1:0] skid_z;
    logic [3:0]       skid_flags;

    logic             accept;
    logic             deliver;
    logic             in_n;
    logic             in_zf;
    logic             in_v;
    logic [3:0]       in_flags;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign out_z     = main_z;
    assign out_flags = main_flags;

    // Condition flags for the incoming result; b_msb arrives uninverted,
    // so subtract overflow needs the operand signs to differ.
    always_comb begin
        in_n  = z[WIDTH-1];
        in_zf = (z == '0);
        if (ctrl == 1'b0) begin
            in_v = (a_msb == b_msb) & (z[WIDTH-1] != a_msb);
        end else begin
            in_v = (a_msb != b_msb) & (z[WIDTH-1] != a_msb);
        end
        in_flags = {in_n, in_zf, cout, in_v};
    end

    // Skid-buffer FSM: main register drives outputs, skid holds the second entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            main_z     <= '0;
            main_flags <= '0;
            skid_z     <= '0;
            skid_flags <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_z     <= z;
                        main_flags <= in_flags;
                        state      <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !deliver) begin
                        skid_z     <= z;
                        skid_flags <= in_flags;
                        state      <= TWO;
                    end else if (!accept && deliver) begin
                        state <= EMPTY;
                    end else if (accept && deliver) begin
                        main_z     <= z;
                        main_flags <= in_flags;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        main_z     <= skid_z;
                        main_flags <= skid_flags;
                        state      <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // Saturating overflow counter; clear takes priority over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= '0;
        end else if (accept && in_v && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_arith_result_stage.sv
// Directed testbench for arith_result_stage. A default instance (CNT_W=8)
// and a narrow-counter instance (CNT_W=4) share all inputs.
module tb_arith_result_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] z;
    logic        cout;
    logic        ctrl;
    logic        a_msb;
    logic        b_msb;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_z;
    logic [3:0]  out_flags;
    logic [7:0]  ovf_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_z4;
    logic [3:0]  out_flags4;
    logic [3:0]  ovf_count4;

    int checks;
    int errors;

    arith_result_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .cout      (cout),
        .ctrl      (ctrl),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_flags (out_flags),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    arith_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .z         (z),
        .cout      (cout),
        .ctrl      (ctrl),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_z     (out_z4),
        .out_flags (out_flags4),
        .clr_count (clr_count),
        .ovf_count (ovf_count4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] zz, input logic c,
                         input logic op, input logic am, input logic bm);
        in_valid = v;
        z        = zz;
        cout     = c;
        ctrl     = op;
        a_msb    = am;
        b_msb    = bm;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        z         = 'x;
        cout      = 1'bx;
        ctrl      = 1'bx;
        a_msb     = 1'bx;
        b_msb     = 1'bx;
        out_ready = 1'b0;
        clr_count = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        checks++;
        if (out_z !== 32'h0 || out_flags !== 4'b0000 || ovf_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_regs: out_z=%h flags=%b ovf=%0d required 0/0000/0", out_z, out_flags, ovf_count);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
        // X on data inputs while in_valid=0 must not disturb state
        checks++;
        if (out_valid !== 1'b0 || out_z !== 32'h0 || out_flags !== 4'b0000 || ovf_count !== 8'h0) begin
            errors++;
            $display("FAIL idle_x_inputs: out_valid=%b out_z=%h flags=%b ovf=%0d required 0/0/0000/0",
                     out_valid, out_z, out_flags, ovf_count);
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'h8000_0000 || out_flags !== 4'b1001) begin
            errors++;
            $display("FAIL add_overflow: out_valid=%b out_z=%h flags=%b required 1/80000000/1001",
                     out_valid, out_z, out_flags);
        end
        checks++;
        if (ovf_count !== 8'd1 || ovf_count4 !== 4'd1) begin
            errors++;
            $display("FAIL add_overflow_count: ovf=%0d ovf4=%0d required 1/1", ovf_count, ovf_count4);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_overflow_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_sub_equal();
        drive(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'h0 || out_flags !== 4'b0110) begin
            errors++;
            $display("FAIL sub_equal: out_valid=%b out_z=%h flags=%b required 1/00000000/0110",
                     out_valid, out_z, out_flags);
        end
        checks++;
        if (ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL sub_equal_count: ovf=%0d required 1", ovf_count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_sub_overflow();
        // a negative, b positive, result positive: signed overflow on subtract
        drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_z !== 32'h7FFF_FFFF || out_flags !== 4'b0011 || ovf_count !== 8'd2) begin
            errors++;
            $display("FAIL sub_overflow: out_z=%h flags=%b ovf=%0d required 7fffffff/0011/2",
                     out_z, out_flags, ovf_count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_z !== 32'h11) begin
            errors++;
            $display("FAIL bp_first: out_valid=%b in_ready=%b out_z=%h required 1/1/11", out_valid, in_ready, out_z);
        end
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_z !== 32'h11) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b out_z=%h required 0/11", in_ready, out_z);
        end
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_z !== 32'h11 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b out_valid=%b out_z=%h flags=%b required 0/1/11/0000",
                     in_ready, out_valid, out_z, out_flags);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_z !== 32'h22 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: out_z=%h in_ready=%b out_valid=%b required 22/1/1", out_z, in_ready, out_valid);
        end
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_z !== 32'h33 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_third: out_z=%h out_valid=%b required 33/1", out_z, out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_z !== 32'(i) || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: out_valid=%b out_z=%h in_ready=%b required 1/%h/1",
                         i, out_valid, out_z, in_ready, 32'(i));
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        checks++;
        if (ovf_count !== 8'd0 || ovf_count4 !== 4'd0) begin
            errors++;
            $display("FAIL sat_clear: ovf=%0d ovf4=%0d required 0/0", ovf_count, ovf_count4);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            if (i == 15) begin
                checks++;
                if (ovf_count4 !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_at15: ovf4=%0d required 15", ovf_count4);
                end
            end
        end
        checks++;
        if (ovf_count4 !== 4'd15 || ovf_count !== 8'd17) begin
            errors++;
            $display("FAIL sat_hold: ovf4=%0d ovf=%0d required 15/17", ovf_count4, ovf_count);
        end
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ovf_count4 !== 4'd0 || ovf_count !== 8'd0) begin
            errors++;
            $display("FAIL sat_clr_wins: ovf4=%0d ovf=%0d required 0/0", ovf_count4, ovf_count);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_two();
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || ovf_count !== 8'd2) begin
            errors++;
            $display("FAIL two_setup: in_ready=%b ovf=%0d required 0/2", in_ready, ovf_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_count !== 8'd0 ||
            out_z !== 32'h0 || out_flags !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b ovf=%0d out_z=%h flags=%b required 0/1/0/0/0000",
                     out_valid, in_ready, ovf_count, out_z, out_flags);
        end
        step();
        reset_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_z !== 32'h7FFF_FFFF || out_flags !== 4'b0011 || ovf_count !== 8'd1) begin
            errors++;
            $display("FAIL post_reset: out_valid=%b out_z=%h flags=%b ovf=%0d required 1/7fffffff/0011/1",
                     out_valid, out_z, out_flags, ovf_count);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_drain: out_valid=%b required 0 (stale skid entry)", out_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_sub_overflow();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_in_two();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arith_result_stage.md
Name: arith_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit add/subtract unit (yArith).
- Captures the adder result `z` and carry `cout` with a valid/ready handshake, then derives the condition flags N, Z, C and V.
- A 2-entry skid buffer sustains one transaction per cycle under backpressure.
- Keeps a saturating count of signed-overflow events for the execute stage and debug.

Parameters:
- WIDTH, 32, datapath width of `z` / `out_z`.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a valid adder result.
- in_ready  output  1  stage can accept; equals (state != TWO).
- z  input  WIDTH  adder result.
- cout  input  1  adder carry-out.
- ctrl  input  1  operation: 0 = add (a+b), 1 = subtract (a+~b+1).
- a_msb  input  1  sign bit of operand a.
- b_msb  input  1  sign bit of operand b, uninverted.
- out_valid  output  1  out_z / out_flags hold a valid entry.
- out_ready  input  1  downstream accepts the entry.
- out_z  output  WIDTH  registered result.
- out_flags  output  4  {N, Z, C, V} for out_z.
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  saturating count of accepted entries with V=1.

Behaviour:
- Handshake
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - Inputs are sampled only on accept.
  - out_z and out_flags are stable while out_valid & !out_ready.
- Flag computation, on the accepted input, stored alongside z:
  - N = z[WIDTH-1].
  - Z = (z == 0).
  - C = cout in both modes; for subtract, C=1 means no borrow.
  - V when ctrl=0: (a_msb == b_msb) & (z[WIDTH-1] != a_msb).
  - V when ctrl=1: (a_msb != b_msb) & (z[WIDTH-1] != a_msb).
- Storage: main register (drives outputs) and skid register.
- FSM states EMPTY, ONE, TWO; out_valid = (state != EMPTY).
  - EMPTY: accept -> ONE, main <= input.
  - ONE, accept & !deliver -> TWO, skid <= input.
  - ONE, deliver & !accept -> EMPTY.
  - ONE, accept & deliver -> ONE, main <= input.
  - ONE, neither -> ONE.
  - TWO: in_ready=0, so no accept. Deliver -> ONE, main <= skid. No deliver -> TWO.
- Latency and throughput
  - Accept in cycle n gives out_valid in cycle n+1.
  - One result per cycle when out_ready is held high.
  - Entries are delivered strictly in accept order; none are lost or duplicated.
- Overflow counter
  - On accept with V=1: ovf_count += 1, saturating at 2^CNT_W-1 (no wrap).
  - clr_count=1 sets ovf_count to 0 next edge; clear wins over a simultaneous increment.
- Reset (reset_n=0, asynchronous, effective immediately, including mid-operation)
  - state=EMPTY, out_valid=0, in_ready=1.
  - out_z=0, out_flags=4'b0000, ovf_count=0.
  - Buffered entries are discarded.
  - Deassertion takes effect at the next clk edge.
- in_valid while in_ready=0: input is ignored; upstream must hold it.
- X on z, cout, ctrl, a_msb or b_msb while in_valid=0 must not propagate into state.

Test Plan:
1. Add overflow: ctrl=0, z=0x80000000, cout=0, a_msb=0, b_msb=0, accepted in cycle n.
   -> cycle n+1: out_valid=1, out_z=0x80000000, out_flags=4'b1001, ovf_count=1.
2. Subtract equal: ctrl=1, z=0x00000000, cout=1, a_msb=b_msb=0.
   -> out_flags=4'b0110, ovf_count unchanged.
3. Backpressure: out_ready=0; offer 0x11, 0x22, 0x33 on consecutive cycles.
   -> 0x11 and 0x22 accepted; in_ready=0 after the second accept; 0x33 held.
   -> out_z stays 0x11.
   -> Raise out_ready: 0x11, 0x22, 0x33 delivered in order.
4. Streaming: out_ready=1, eight back-to-back values 1..8.
   -> out_valid high for 8 consecutive cycles starting one cycle after the first accept; values 1..8 with no bubbles.
5. Saturation: CNT_W=4, 17 accepted overflowing inputs.
   -> ovf_count=15.
   -> Then clr_count=1 together with an overflowing accept gives ovf_count=0.
6. Reset in TWO state: drop reset_n mid-cycle.
   -> out_valid=0 and in_ready=1 before the next edge, ovf_count=0.
   -> After release, a new accept appears with correct flags.
